// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// when undefined, read data is registered with one cycle of latency.
module sync_fifo_param #(
  parameter int unsigned D_SIZE   = 8,
  parameter int unsigned A_SIZE   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_w_inc,
  input  logic [D_SIZE-1:0] i_w_data,
  input  logic              i_r_inc,
  input  logic              i_clr_err,
  output logic [D_SIZE-1:0] o_r_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [A_SIZE:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int unsigned DEPTH = 1 << A_SIZE;
  localparam int unsigned PW    = A_SIZE + 1;

  logic [D_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     count_next;
  logic [A_SIZE-1:0] wr_addr;
  logic [A_SIZE-1:0] rd_addr;
  logic              wr_ok;
  logic              rd_ok;

  // Accept qualifiers use the registered flags, so rejected ops never move pointers
  assign wr_ok   = i_w_inc & ~o_full;
  assign rd_ok   = i_r_inc & ~o_empty;
  assign wr_addr = wr_ptr[A_SIZE-1:0];
  assign rd_addr = rd_ptr[A_SIZE-1:0];

  // Next occupancy; flags are derived from it so they line up with o_count
  always_comb begin
    count_next = o_count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = o_count + PW'(1);
      2'b01:   count_next = o_count - PW'(1);
      default: count_next = o_count;
    endcase
  end

  // Storage array; deliberately not reset
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= i_w_data;
    end
  end

  // Binary pointers with wrap bit; wrap is natural modulo arithmetic
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Registered count and status flags
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_count        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      o_count        <= count_next;
      o_full         <= (count_next == PW'(DEPTH));
      o_empty        <= (count_next == '0);
      o_almost_full  <= (count_next >= PW'(AF_LEVEL));
      o_almost_empty <= (count_next <= PW'(AE_LEVEL));
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_w_inc & o_full)     o_overflow <= 1'b1;
      else if (i_clr_err)       o_overflow <= 1'b0;
      if (i_r_inc & o_empty)    o_underflow <= 1'b1;
      else if (i_clr_err)       o_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; i_r_inc acknowledges and advances
  assign o_r_data = mem[rd_addr];
`else
  // Registered read: head word appears the cycle after an accepted read
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_r_data <= '0;
    end else if (rd_ok) begin
      o_r_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for sync_fifo_param
// (D_SIZE=8, A_SIZE=4, AF_LEVEL=12, AE_LEVEL=4). Honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rstn;
  logic       w_inc;
  logic [7:0] w_data;
  logic       r_inc;
  logic       clr_err;
  logic [7:0] r_data;
  logic       full, empty, afull, aempty, ovf, unf;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.D_SIZE(8), .A_SIZE(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_w_inc(w_inc), .i_w_data(w_data),
    .i_r_inc(r_inc), .i_clr_err(clr_err), .o_r_data(r_data),
    .o_full(full), .o_empty(empty), .o_almost_full(afull),
    .o_almost_empty(aempty), .o_count(count), .o_overflow(ovf),
    .o_underflow(unf)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_compare();
    logic [7:0] exp;
    if (sb.size() == 0) begin
      check("sb_unexpected_read", 1, 0);
    end else begin
      exp = sb.pop_front();
      check("rdata", int'(r_data), int'(exp));
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  // Zero latency: head must be visible while the pop is being requested
  always @(negedge clk) begin
    if (rstn && r_inc && !empty) pop_compare();
  end
`else
  // One cycle latency: data checked after the edge that accepted the read
  logic pend = 1'b0;
  always @(posedge clk) pend <= rstn && r_inc && !empty;
  always @(negedge clk) begin
    if (pend) pop_compare();
  end
`endif

  // Tasks start and end at posedge+1
  task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic clr);
    w_inc = w; w_data = wd; r_inc = r; clr_err = clr;
    @(posedge clk); #1;
    w_inc = 1'b0; r_inc = 1'b0; clr_err = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input logic push);
    if (push) sb.push_back(d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; w_inc = 1'b0; w_data = 8'h00; r_inc = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset / idle state
    check("rst_empty", int'(empty), 1);
    check("rst_aempty", int'(aempty), 1);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_afull", int'(afull), 0);
    check("rst_errs", int'({ovf, unf}), 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rdata", int'(r_data), 0);
`endif

    // Fill 0x01..0x10 and track thresholds after every write
    for (int k = 1; k <= 16; k++) begin
      wr(8'(k), 1'b1);
      check("fill_count", int'(count), k);
      check("fill_aempty", int'(aempty), (k <= 4) ? 1 : 0);
      check("fill_afull", int'(afull), (k >= 12) ? 1 : 0);
      check("fill_full", int'(full), (k == 16) ? 1 : 0);
      check("fill_empty", int'(empty), 0);
    end
    check("pre_ovf", int'(ovf), 0);
    wr(8'hEE, 1'b0);
    check("ovf_set", int'(ovf), 1);
    check("ovf_count", int'(count), 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", int'(ovf), 0);

    // Drain all 16 in order
    for (int k = 1; k <= 16; k++) rd();
    check("drain_empty", int'(empty), 1);
    check("drain_count", int'(count), 0);
    check("drain_unf0", int'(unf), 0);
    rd();
    check("unf_set", int'(unf), 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("unf_hold_rdata", int'(r_data), 8'h10);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_clr", int'(unf), 0);

    // Fill to 8, then 20 cycles of simultaneous read+write across wrap
    for (int k = 0; k < 8; k++) wr(8'(8'h20 + k), 1'b1);
    for (int k = 0; k < 20; k++) begin
      sb.push_back(8'(8'h28 + k));
      step(1'b1, 8'(8'h28 + k), 1'b1, 1'b0);
      check("rw_count", int'(count), 8);
    end
    check("rw_errs", int'({ovf, unf}), 0);
    for (int k = 0; k < 8; k++) rd();
    check("rw_drain_empty", int'(empty), 1);

    // Simultaneous read+write when full: read wins, write dropped
    for (int k = 0; k < 16; k++) wr(8'(8'h40 + k), 1'b1);
    check("full2", int'(full), 1);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fullrw_count", int'(count), 15);
    check("fullrw_ovf", int'(ovf), 1);
    check("fullrw_full", int'(full), 0);
    for (int k = 0; k < 15; k++) rd();
    check("fullrw_empty", int'(empty), 1);

    // Simultaneous read+write when empty: write wins, read rejected
    sb.push_back(8'h55);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("emptyrw_count", int'(count), 1);
    check("emptyrw_unf", int'(unf), 1);
    check("emptyrw_empty", int'(empty), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_both", int'({ovf, unf}), 0);
    rd();
    check("emptyrw_drain", int'(count), 0);

    // Asynchronous reset mid-operation with 10 words stored
    for (int k = 0; k < 10; k++) wr(8'(8'h60 + k), 1'b1);
    check("pre_rst_count", int'(count), 10);
    #2 rstn = 1'b0;
    #1;
    sb.delete();
    check("arst_count", int'(count), 0);
    check("arst_empty", int'(empty), 1);
    check("arst_aempty", int'(aempty), 1);
    check("arst_flags", int'({full, afull, ovf, unf}), 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("arst_rdata", int'(r_data), 0);
`endif
    @(posedge clk); #1 rstn = 1'b1;
    wr(8'h77, 1'b1);
    check("post_rst_count", int'(count), 1);
    rd();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_empty", int'(empty), 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
